// File: rtl/dm_load_unit_pkg.sv
// rtl/dm_load_unit_pkg.sv - shared memory-access type, exception and load FSM codes
//
// Purpose: type codes shared by the M-stage store path and the load unit,
//          load exception codes, load FSM state encoding and small decode helpers.
// Ports:   none (package).
package dm_load_unit_pkg;

  // Store type codes (M-stage store byte-enable path).
  localparam logic [2:0] ST_SW = 3'b001;
  localparam logic [2:0] ST_SH = 3'b010;
  localparam logic [2:0] ST_SB = 3'b100;

  // Load type codes; every other code is illegal.
  localparam logic [2:0] LD_LW  = 3'b001;
  localparam logic [2:0] LD_LH  = 3'b010;
  localparam logic [2:0] LD_LHU = 3'b011;
  localparam logic [2:0] LD_LB  = 3'b100;
  localparam logic [2:0] LD_LBU = 3'b101;

  // Load response exception codes.
  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_ADEL = 2'b01;
  localparam logic [1:0] EXC_TMO  = 2'b10;
  localparam logic [1:0] EXC_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } loadState_e;

  function automatic logic isLegalLoad(input logic [2:0] loadType);
    return (loadType == LD_LW) || (loadType == LD_LH) || (loadType == LD_LHU) ||
           (loadType == LD_LB) || (loadType == LD_LBU);
  endfunction

  // Words need 4-byte alignment, halfwords 2-byte; bytes are always aligned.
  function automatic logic isMisaligned(input logic [2:0] loadType, input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    if (loadType == LD_LW) begin
      mis = (offset != 2'b00);
    end else if ((loadType == LD_LH) || (loadType == LD_LHU)) begin
      mis = offset[0];
    end
    return mis;
  endfunction

endpackage

// File: rtl/load_data_ext.sv
// rtl/load_data_ext.sv - byte/halfword select and sign/zero extension of a loaded word
//
// Purpose: pure combinational extraction of the addressed lane from a 32-bit
//          memory word and extension to 32 bits. Also used by the W-stage
//          when the load unit is bypassed.
// Ports:   word     in  32  raw memory word
//          offset   in  2   byte offset inside the word (addr[1:0])
//          loadType in  3   load type code
//          result   out 32  extended load value
module load_data_ext
  import dm_load_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  loadType,
  output logic [31:0] result
);

  logic [15:0] halfSel;
  logic [7:0]  byteSel;

  always_comb begin
    halfSel = offset[1] ? word[31:16] : word[15:0];
    case (offset)
      2'd0:    byteSel = word[7:0];
      2'd1:    byteSel = word[15:8];
      2'd2:    byteSel = word[23:16];
      default: byteSel = word[31:24];
    endcase
  end

  // Illegal codes never reach here from the load unit; they fall through as LW.
  always_comb begin
    result = word;
    case (loadType)
      LD_LH:   result = {{16{halfSel[15]}}, halfSel};
      LD_LHU:  result = {16'h0000, halfSel};
      LD_LB:   result = {{24{byteSel[7]}}, byteSel};
      LD_LBU:  result = {24'h00_0000, byteSel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/dm_load_unit.sv
// rtl/dm_load_unit.sv - M-stage data-memory load unit with exception reporting
//
// Purpose: accepts one load request, issues a word-aligned read, waits for the
//          read data, extends the addressed lane and returns it through a
//          valid/ready response. Reports misaligned, illegal-type and timeout.
// Ports:   clk, reset (async, active-low)
//          req_valid/req_ready/req_addr/req_type     load request handshake
//          mem_rd_en/mem_addr/mem_gnt                read request to data memory
//          mem_rvalid/mem_rdata                      read data return
//          rsp_valid/rsp_ready/rsp_data/rsp_exc      response handshake
module dm_load_unit
  import dm_load_unit_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 16
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_type,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_exc
);

  // Counter value of the last WAIT cycle before the timeout fires.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  loadState_e       state;
  loadState_e       nextState;
  logic [31:0]      addrReg;
  logic [2:0]       typeReg;
  logic [CNT_W-1:0] waitCnt;
  logic [31:0]      rspDataReg;
  logic [1:0]       rspExcReg;
  logic [31:0]      extData;
  logic             reqReject;

  assign reqReject = !isLegalLoad(req_type) || isMisaligned(req_type, req_addr[1:0]);

  load_data_ext uExt (
    .word     (mem_rdata),
    .offset   (addrReg[1:0]),
    .loadType (typeReg),
    .result   (extData)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (req_valid) nextState = reqReject ? RESP : ISSUE;
      ISSUE:   if (mem_gnt) nextState = mem_rvalid ? RESP : WAIT;
      // rvalid on the final counting cycle still lands in RESP, as data.
      WAIT:    if (mem_rvalid || (waitCnt == CNT_LAST)) nextState = RESP;
      RESP:    if (rsp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes.
  always_comb begin
    req_ready = (state == IDLE);
    mem_rd_en = (state == ISSUE);
    rsp_valid = (state == RESP);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addrReg    <= '0;
      typeReg    <= '0;
      waitCnt    <= '0;
      rspDataReg <= '0;
      rspExcReg  <= EXC_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addrReg    <= req_addr;
            typeReg    <= req_type;
            rspDataReg <= '0;
            if (!isLegalLoad(req_type)) begin
              rspExcReg <= EXC_ILL;
            end else if (isMisaligned(req_type, req_addr[1:0])) begin
              rspExcReg <= EXC_ADEL;
            end else begin
              rspExcReg <= EXC_NONE;
            end
          end
        end
        ISSUE: begin
          if (mem_gnt) begin
            waitCnt <= '0;
            if (mem_rvalid) begin
              rspDataReg <= extData;
              rspExcReg  <= EXC_NONE;
            end
          end
        end
        WAIT: begin
          waitCnt <= waitCnt + CNT_W'(1);
          if (mem_rvalid) begin
            rspDataReg <= extData;
            rspExcReg  <= EXC_NONE;
          end else if (waitCnt == CNT_LAST) begin
            rspDataReg <= '0;
            rspExcReg  <= EXC_TMO;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr = {addrReg[31:2], 2'b00};
  assign rsp_data = rspDataReg;
  assign rsp_exc  = rspExcReg;

endmodule

// File: tb/tb_dm_load_unit.sv
// tb/tb_dm_load_unit.sv - self-checking bench for dm_load_unit
module tb_dm_load_unit;

  localparam int TMO = 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_type;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_exc;

  dm_load_unit #(.TIMEOUT_CYC(TMO), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_type   (req_type),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_exc    (rsp_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFails  = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: {exc, data} of a load from the architectural rules.
  function automatic logic [33:0] modelLoad(input logic [31:0] addr, input logic [2:0] typ,
                                            input logic [31:0] word, input bit timedOut);
    int          sz;
    logic [31:0] v;
    logic [31:0] mask;
    bit          sgn;
    if (!(typ >= 3'd1 && typ <= 3'd5)) return {2'b11, 32'h0};
    sz = (typ == 3'd1) ? 4 : ((typ <= 3'd3) ? 2 : 1);
    if ((addr % sz) != 0) return {2'b01, 32'h0};
    if (timedOut) return {2'b10, 32'h0};
    if (sz == 4) return {2'b00, word};
    v    = word >> (8 * addr[1:0]);
    mask = (sz == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
    sgn  = (typ == 3'd2) || (typ == 3'd4);
    v    = v & mask;
    if (sgn && (v > (mask >> 1))) v = v | ~mask;
    return {2'b00, v};
  endfunction

  logic [33:0] expQ[$];
  bit          expIdle = 1'b1;
  bit          cmpEn   = 1'b0;
  logic [31:0] expMemAddr = 32'h0;
  int          rdEnCnt = 0;

  // Per-cycle comparison of DUT outputs against the expected transaction.
  always @(negedge clk) begin
    if (cmpEn) begin
      check32("req_ready", req_ready, expIdle);
      if (expIdle) check32("rsp_valid_idle", rsp_valid, 0);
      if (mem_rd_en) begin
        rdEnCnt++;
        check32("mem_addr", mem_addr, expMemAddr);
      end
      if (rsp_valid) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("FAIL rsp_unexpected: got rsp_valid=1, expected no response");
        end else begin
          check32("rsp_data", rsp_data, expQ[0][31:0]);
          check32("rsp_exc", rsp_exc, expQ[0][33:32]);
          if (rsp_ready) void'(expQ.pop_front());
        end
      end
    end
  end

  task automatic runLoad(input string name, input logic [31:0] addr, input logic [2:0] typ,
                         input logic [31:0] word, input int gntDly, input int rvDly,
                         input bit noRv, input int rdyDly,
                         input logic [1:0] litExc, input logic [31:0] litData);
    logic [33:0] m;
    logic [33:0] probe;
    bit          access;
    int          expLat;
    int          lat;
    probe  = modelLoad(addr, typ, word, 1'b0);
    access = (probe[33:32] == 2'b00);
    m      = modelLoad(addr, typ, word, noRv);
    check32({name, "_model_exc"}, m[33:32], litExc);
    check32({name, "_model_data"}, m[31:0], litData);
    expQ.push_back(m);
    expMemAddr = addr & 32'hFFFF_FFFC;
    rdEnCnt    = 0;
    expLat     = !access ? 1 : (2 + gntDly + (noRv ? TMO : rvDly));
    mem_rdata  = word;
    req_valid  = 1'b1;
    req_addr   = addr;
    req_type   = typ;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom();
    req_type  = 3'($urandom());
    expIdle   = 1'b0;
    lat       = 0;
    fork
      begin
        if (access) begin
          repeat (gntDly) begin @(posedge clk); #1; end
          mem_gnt    = 1'b1;
          mem_rvalid = (rvDly == 0) && !noRv;
          @(posedge clk); #1;
          mem_gnt    = 1'b0;
          mem_rvalid = 1'b0;
          if (!noRv && rvDly > 0) begin
            repeat (rvDly - 1) begin @(posedge clk); #1; end
            mem_rvalid = 1'b1;
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
          end
        end
      end
      begin
        for (int c = 1; c <= 40; c++) begin
          @(negedge clk);
          if (rsp_valid) begin
            lat = c;
            break;
          end
        end
      end
    join
    check32({name, "_latency"}, lat, expLat);
    if (lat == 0) begin
      expQ.delete();
      expIdle = 1'b1;
      return;
    end
    @(posedge clk); #1;
    repeat (rdyDly) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    expIdle   = 1'b1;
    check32({name, "_rd_en_cycles"}, rdEnCnt, access ? (gntDly + 1) : 0);
    check32({name, "_rsp_consumed"}, expQ.size(), 0);
    mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    req_type   = 3'b000;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    rsp_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_req_ready", req_ready, 1);
    check32("rst_mem_rd_en", mem_rd_en, 0);
    check32("rst_mem_addr", mem_addr, 0);
    check32("rst_rsp_valid", rsp_valid, 0);
    check32("rst_rsp_data", rsp_data, 0);
    check32("rst_rsp_exc", rsp_exc, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    cmpEn = 1'b1;
    @(posedge clk); #1;

    //       name     addr          type    word          gnt rv noRv rdy exc    data
    runLoad("lb_3",   32'h0000_1003, 3'b100, 32'h80FF_1234, 1, 0, 0, 0, 2'b00, 32'hFFFF_FF80);
    runLoad("lbu_2",  32'h0000_1002, 3'b101, 32'h80FF_1234, 0, 0, 0, 0, 2'b00, 32'h0000_00FF);
    runLoad("lhu_2",  32'h0000_1002, 3'b011, 32'h80FF_1234, 0, 2, 0, 0, 2'b00, 32'h0000_80FF);
    runLoad("lw_mis", 32'h0000_1002, 3'b001, 32'h80FF_1234, 0, 0, 0, 0, 2'b01, 32'h0000_0000);
    runLoad("ill_7",  32'h0000_1000, 3'b111, 32'h80FF_1234, 0, 0, 0, 0, 2'b11, 32'h0000_0000);
    runLoad("lh_stl", 32'h0000_2000, 3'b010, 32'h1234_8001, 3, 1, 0, 4, 2'b00, 32'hFFFF_8001);
    runLoad("lw_tmo", 32'h0000_3000, 3'b001, 32'h5555_AAAA, 0, 0, 1, 0, 2'b10, 32'h0000_0000);
    runLoad("lw_lst", 32'h0000_3004, 3'b001, 32'hCAFE_F00D, 0, 4, 0, 1, 2'b00, 32'hCAFE_F00D);
    runLoad("lb_1",   32'h0000_1001, 3'b100, 32'h80FF_1234, 0, 0, 0, 0, 2'b00, 32'h0000_0012);
    runLoad("lh_2",   32'h0000_1002, 3'b010, 32'h80FF_1234, 0, 1, 0, 0, 2'b00, 32'hFFFF_80FF);
    runLoad("lh_mis", 32'h0000_1001, 3'b010, 32'h80FF_1234, 0, 0, 0, 0, 2'b01, 32'h0000_0000);
    runLoad("lbu_3",  32'h0000_1003, 3'b101, 32'h80FF_1234, 0, 0, 0, 2, 2'b00, 32'h0000_0080);
    runLoad("ill_0",  32'h0000_1000, 3'b000, 32'h80FF_1234, 0, 0, 0, 0, 2'b11, 32'h0000_0000);
    runLoad("ill_6",  32'h0000_1000, 3'b110, 32'h80FF_1234, 0, 0, 0, 0, 2'b11, 32'h0000_0000);
    runLoad("lhu_0",  32'h0000_1000, 3'b011, 32'h1234_F00F, 2, 1, 0, 0, 2'b00, 32'h0000_F00F);
    runLoad("lw_t1",  32'h0000_4008, 3'b001, 32'h0BAD_F00D, 1, 1, 0, 0, 2'b00, 32'h0BAD_F00D);

    // Stray read data while idle must not produce a response.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1111_2222;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of WAIT, then a stale rvalid after release.
    cmpEn     = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h0000_4000;
    req_type  = 3'b001;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_gnt   = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check32("abort_req_ready", req_ready, 1);
    check32("abort_mem_rd_en", mem_rd_en, 0);
    check32("abort_mem_addr", mem_addr, 0);
    check32("abort_rsp_valid", rsp_valid, 0);
    check32("abort_rsp_data", rsp_data, 0);
    check32("abort_rsp_exc", rsp_exc, 0);
    @(posedge clk); #1;
    reset      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h7777_8888;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check32("stale_rsp_valid", rsp_valid, 0);
      check32("stale_req_ready", req_ready, 1);
      check32("stale_mem_rd_en", mem_rd_en, 0);
    end
    @(posedge clk); #1;
    expQ.delete();
    expIdle = 1'b1;
    cmpEn   = 1'b1;
    runLoad("post_rst", 32'h0000_5002, 3'b100, 32'hA1B2_C3D4, 0, 0, 0, 0, 2'b00, 32'hFFFF_FFB2);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
